// File: rtl/ifc_pkg.sv
// Shared definitions for the OR-unit register-interface initiator:
// bus address map, FSM state encoding and a small state classifier.
package ifc_pkg;

  localparam logic [2:0] ADDR_A_STS  = 3'd0;
  localparam logic [2:0] ADDR_B_STS  = 3'd1;
  localparam logic [2:0] ADDR_Y_STS  = 3'd2;
  localparam logic [2:0] ADDR_Y_DATA = 3'd3;
  localparam logic [2:0] ADDR_A_DATA = 3'd4;
  localparam logic [2:0] ADDR_B_DATA = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POLL_A = 3'd1,
    WR_A   = 3'd2,
    POLL_B = 3'd3,
    WR_B   = 3'd4,
    POLL_Y = 3'd5,
    RD_Y   = 3'd6,
    RSP    = 3'd7
  } ifc_init_state_t;

  function automatic logic is_poll(input ifc_init_state_t s);
    return (s == POLL_A) || (s == POLL_B) || (s == POLL_Y);
  endfunction

endpackage

// File: rtl/ifc_poll_timer.sv
// Counts unsuccessful status polls and flags the poll that reaches POLL_TIMEOUT.
// A POLL_TIMEOUT of 0 disables both counting and expiry.
module ifc_poll_timer #(
  parameter int POLL_TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam bit              ENABLED  = (POLL_TIMEOUT != 0);
  localparam int              CW       = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT + 1) : 1;
  localparam int              LAST     = (POLL_TIMEOUT > 0) ? POLL_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0]   LAST_CNT = CW'(LAST);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && ENABLED) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expiry fires on the zero poll that would bring the count up to POLL_TIMEOUT.
  assign o_expire = ENABLED && i_inc && (r_cnt == LAST_CNT);

endmodule

// File: rtl/ifc_initiator.sv
// Requester-side bus initiator: writes operands A/B after polling FIFO status,
// polls Y status, reads Y and returns it on a valid/ready response channel.
module ifc_initiator
  import ifc_pkg::*;
#(
  parameter int POLL_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_a,
  input  logic             cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_y,
  output logic [2:0]       write_address,
  output logic             write_data,
  output logic             write_en,
  input  logic             write_rdy,
  output logic [2:0]       read_address,
  output logic             read_en,
  input  logic             read_data,
  input  logic             read_rdy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] txn_count
);

  ifc_init_state_t  r_state;
  ifc_init_state_t  w_next;
  logic             r_a;
  logic             r_b;
  logic             r_rsp_y;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_txn_count;

  logic w_in_poll;
  logic w_in_write;
  logic w_accept;
  logic w_poll_zero;
  logic w_poll_clear;
  logic w_expire;
  logic w_rsp_done;

  assign w_in_poll  = is_poll(r_state);
  assign w_in_write = (r_state == WR_A) || (r_state == WR_B);

  // cmd_ready drops combinationally with RST even though the state is already IDLE.
  assign cmd_ready  = (r_state == IDLE) && !RST;
  assign w_accept   = cmd_valid && cmd_ready;

  assign write_en   = w_in_write && write_rdy;
  assign read_en    = (w_in_poll || (r_state == RD_Y)) && read_rdy;

  assign write_address = (r_state == WR_A) ? ADDR_A_DATA :
                         (r_state == WR_B) ? ADDR_B_DATA : 3'd0;
  assign write_data    = (r_state == WR_A) ? r_a :
                         (r_state == WR_B) ? r_b : 1'b0;

  always_comb begin
    read_address = 3'd0;
    case (r_state)
      POLL_A:  read_address = ADDR_A_STS;
      POLL_B:  read_address = ADDR_B_STS;
      POLL_Y:  read_address = ADDR_Y_STS;
      RD_Y:    read_address = ADDR_Y_DATA;
      default: read_address = 3'd0;
    endcase
  end

  assign w_poll_zero  = read_en && w_in_poll && !read_data;
  assign w_poll_clear = is_poll(w_next) && (w_next != r_state);
  assign w_rsp_done   = (r_state == RSP) && rsp_ready;

  ifc_poll_timer #(
    .POLL_TIMEOUT (POLL_TIMEOUT)
  ) u_poll_timer (
    .CLK      (CLK),
    .RST      (RST),
    .i_clear  (w_poll_clear),
    .i_inc    (w_poll_zero),
    .o_expire (w_expire)
  );

  // NOTE: next-state defaults to the current state first so no path leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_next = POLL_A;
      POLL_A: if (read_en) w_next = read_data ? WR_A : (w_expire ? IDLE : POLL_A);
      WR_A:   if (write_en) w_next = POLL_B;
      POLL_B: if (read_en) w_next = read_data ? WR_B : (w_expire ? IDLE : POLL_B);
      WR_B:   if (write_en) w_next = POLL_Y;
      POLL_Y: if (read_en) w_next = read_data ? RD_Y : (w_expire ? IDLE : POLL_Y);
      RD_Y:   if (read_en) w_next = RSP;
      RSP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE;
      r_a           <= 1'b0;
      r_b           <= 1'b0;
      r_rsp_y       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_txn_count   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a <= cmd_a;
        r_b <= cmd_b;
      end
      if ((r_state == RD_Y) && read_en) r_rsp_y <= read_data;
      if (w_expire) r_timeout_err <= 1'b1;
      if (w_rsp_done) r_txn_count <= r_txn_count + CNT_W'(1);
    end
  end

  assign rsp_valid   = (r_state == RSP);
  assign rsp_y       = r_rsp_y;
  assign timeout_err = r_timeout_err;
  assign txn_count   = r_txn_count;

endmodule

// File: tb/tb_ifc_initiator.sv
// Randomised bench for ifc_initiator: an OR-unit responder model answers the bus,
// and expected bus traces, results and counters come from command-level rules.
module tb_ifc_initiator;

  localparam int PT = 11;
  localparam int CW = 3;

  logic          CLK;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_a;
  logic          cmd_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_y;
  logic [2:0]    write_address;
  logic          write_data;
  logic          write_en;
  logic          write_rdy;
  logic [2:0]    read_address;
  logic          read_en;
  logic          read_data;
  logic          read_rdy;
  logic          timeout_err;
  logic [CW-1:0] txn_count;

  int total = 0;
  int bad = 0;
  int exp_txn = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int viol = 0;
  int rsp_seen = 0;

  int   z_cfg [3];
  int   poll_cnt [3];
  logic y_a;
  logic y_b;

  logic [4:0] trace [$];
  logic [4:0] exp_q [$];

  ifc_initiator #(
    .POLL_TIMEOUT (PT),
    .CNT_W        (CW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_y         (rsp_y),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy),
    .timeout_err   (timeout_err),
    .txn_count     (txn_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Responder: each status address answers 0 for its first z_cfg polls of a command, Y = A | B.
  always_comb begin
    case (read_address)
      3'd0:    read_data = (poll_cnt[0] >= z_cfg[0]);
      3'd1:    read_data = (poll_cnt[1] >= z_cfg[1]);
      3'd2:    read_data = (poll_cnt[2] >= z_cfg[2]);
      3'd3:    read_data = y_a | y_b;
      default: read_data = 1'b0;
    endcase
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      poll_cnt[0] <= 0;
      poll_cnt[1] <= 0;
      poll_cnt[2] <= 0;
      y_a <= 1'b0;
      y_b <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        poll_cnt[0] <= 0;
        poll_cnt[1] <= 0;
        poll_cnt[2] <= 0;
      end else if (read_en) begin
        if (read_address == 3'd0) poll_cnt[0] <= poll_cnt[0] + 1;
        if (read_address == 3'd1) poll_cnt[1] <= poll_cnt[1] + 1;
        if (read_address == 3'd2) poll_cnt[2] <= poll_cnt[2] + 1;
      end
      if (write_en && write_address == 3'd4) y_a <= write_data;
      if (write_en && write_address == 3'd5) y_b <= write_data;
    end
  end

  // Bus monitor, sampled mid-cycle: records fired transfers and protocol violations.
  always @(negedge CLK) begin
    if (read_en)  trace.push_back({1'b0, read_address, 1'b0});
    if (write_en) trace.push_back({1'b1, write_address, write_data});
    if (write_en && !write_rdy) viol++;
    if (read_en && !read_rdy) viol++;
    if (write_en && read_en) viol++;
    if (rsp_valid) rsp_seen++;
  end

  // Ready driver: 0 always ready, 1 three low then one high, 2 random, 3 stall WR_B writes.
  initial begin
    write_rdy = 1'b1;
    read_rdy  = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      case (rdy_mode)
        1: begin
          write_rdy = (cyc % 4 == 3);
          read_rdy  = (cyc % 4 == 3);
        end
        2: begin
          write_rdy = 1'($urandom_range(0, 1));
          read_rdy  = 1'($urandom_range(0, 1));
        end
        3: begin
          write_rdy = (write_address != 3'd5);
          read_rdy  = 1'b1;
        end
        default: begin
          write_rdy = 1'b1;
          read_rdy  = 1'b1;
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic build_exp(input logic a, input logic b, input int na, input int nb,
                           input int ny, input bit timed_out);
    exp_q.delete();
    for (int i = 0; i <= na; i++) exp_q.push_back({1'b0, 3'd0, 1'b0});
    exp_q.push_back({1'b1, 3'd4, a});
    for (int i = 0; i <= nb; i++) exp_q.push_back({1'b0, 3'd1, 1'b0});
    exp_q.push_back({1'b1, 3'd5, b});
    if (timed_out) begin
      for (int i = 0; i < ny; i++) exp_q.push_back({1'b0, 3'd2, 1'b0});
    end else begin
      for (int i = 0; i <= ny; i++) exp_q.push_back({1'b0, 3'd2, 1'b0});
      exp_q.push_back({1'b0, 3'd3, 1'b0});
    end
  endtask

  function automatic bit trace_ok(input int t0);
    if (trace.size() - t0 != exp_q.size()) return 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (trace[t0 + i] !== exp_q[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic start_cmd(input logic a, input logic b, output bit ok);
    int k;
    @(posedge CLK);
    #2;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!cmd_ready && k < 50);
    ok = cmd_ready;
    @(posedge CLK);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic a, input logic b, input int na, input int nb, input int ny,
                         input int hold, input bit early, input int exp_lat);
    int   t0;
    int   k;
    bit   ok;
    bit   busy_ok;
    bit   stable;
    logic y0;
    z_cfg[0] = na;
    z_cfg[1] = nb;
    z_cfg[2] = ny;
    build_exp(a, b, na, nb, ny, 1'b0);
    t0 = trace.size();
    rsp_ready = early;
    start_cmd(a, b, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cmd_accept: cmd_ready=%b, want 1", cmd_ready);
      rsp_ready = 1'b0;
      return;
    end
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge CLK);
      k++;
      if (cmd_ready) busy_ok = 1'b0;
    end while (!rsp_valid && k < 2000);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, want 1", rsp_valid, k);
      rsp_ready = 1'b0;
      return;
    end
    if (exp_lat > 0) begin
      total++;
      if (k !== exp_lat) begin
        bad++;
        $display("FAIL latency: rsp_valid in cycle %0d, want %0d", k, exp_lat);
      end
    end
    total++;
    if (rsp_y !== (a | b)) begin
      bad++;
      $display("FAIL rsp_y: got %b want %b (a=%b b=%b)", rsp_y, a | b, a, b);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL busy_hold: cmd_ready seen 1 while busy, want 0");
    end
    if (!early) begin
      stable = 1'b1;
      y0 = rsp_y;
      repeat (hold) begin
        @(negedge CLK);
        if (rsp_valid !== 1'b1 || rsp_y !== y0) stable = 1'b0;
      end
      if (hold > 0) begin
        total++;
        if (!stable) begin
          bad++;
          $display("FAIL rsp_hold: rsp_valid=%b rsp_y=%b, want 1 and %b held", rsp_valid, rsp_y, y0);
        end
      end
      #1;
      rsp_ready = 1'b1;
    end
    @(posedge CLK);
    #2;
    rsp_ready = 1'b0;
    exp_txn = (exp_txn + 1) % (1 << CW);
    @(negedge CLK);
    total++;
    if (txn_count !== CW'(exp_txn)) begin
      bad++;
      $display("FAIL txn_count: got %0d want %0d", txn_count, exp_txn);
    end
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_drop: rsp_valid=%b after handshake, want 0", rsp_valid);
    end
    total++;
    if (!trace_ok(t0)) begin
      bad++;
      $display("FAIL bus_trace: got %0d transfers want %0d, or order/data differs",
               trace.size() - t0, exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    total++;
    if ({cmd_ready, rsp_valid, rsp_y, write_en, read_en, timeout_err, write_data} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {cmd_ready, rsp_valid, rsp_y, write_en, read_en, timeout_err, write_data});
    end
    total++;
    if ({write_address, read_address} !== 6'd0) begin
      bad++;
      $display("FAIL reset_addr: got %b want 000000", {write_address, read_address});
    end
    total++;
    if (txn_count !== '0) begin
      bad++;
      $display("FAIL reset_txn: got %0d want 0", txn_count);
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL idle_after_reset: cmd_ready,rsp_valid=%b want 10", {cmd_ready, rsp_valid});
    end
    total++;
    if (txn_count !== '0) begin
      bad++;
      $display("FAIL idle_rsp_ready: txn_count=%0d want 0", txn_count);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] p;
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      p = 2'(i);
      run_cmd(p[1], p[0], 0, 0, 0, 0, 1'b0, 7);
    end
  endtask

  task automatic test_back_pressure();
    int v0;
    logic [1:0] p;
    v0 = viol;
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      p = 2'($urandom_range(0, 3));
      run_cmd(p[1], p[0], 0, 0, 0, 0, 1'(i % 2), 0);
    end
    total++;
    if (viol !== v0) begin
      bad++;
      $display("FAIL bus_protocol: %0d enable pulses without rdy or overlapping, want 0", viol - v0);
    end
  endtask

  task automatic test_a_full_stall();
    rdy_mode = 0;
    run_cmd(1'b1, 1'b0, 10, 0, 0, 0, 1'b0, 17);
    run_cmd(1'b0, 1'b1, 0, 0, PT - 1, 0, 1'b0, 7 + PT - 1);
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_timeout: timeout_err=%b want 0", timeout_err);
    end
  endtask

  task automatic test_rsp_wrap();
    logic a;
    logic b;
    rdy_mode = 2;
    for (int i = 0; i < (1 << CW); i++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      run_cmd(a, b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              (i == 0) ? 5 : $urandom_range(0, 3), 1'b0, 0);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int k;
    int s0;
    bit ok;
    rdy_mode = 2;
    z_cfg[0] = 0;
    z_cfg[1] = 0;
    z_cfg[2] = 1000;
    build_exp(1'b1, 1'b1, 0, 0, PT, 1'b1);
    t0 = trace.size();
    s0 = rsp_seen;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pre: timeout_err=%b want 0", timeout_err);
    end
    start_cmd(1'b1, 1'b1, ok);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!cmd_ready && k < 3000);
    total++;
    if (!ok || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL timeout_idle: accepted=%b cmd_ready=%b, want 1 and 1", ok, cmd_ready);
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_flag: timeout_err=%b want 1", timeout_err);
    end
    total++;
    if (!trace_ok(t0)) begin
      bad++;
      $display("FAIL timeout_polls: got %0d transfers want %0d (exactly %0d Y polls)",
               trace.size() - t0, exp_q.size(), PT);
    end
    total++;
    if (rsp_seen !== s0) begin
      bad++;
      $display("FAIL timeout_rsp: rsp_valid seen %0d cycles, want 0", rsp_seen - s0);
    end
    total++;
    if (txn_count !== CW'(exp_txn)) begin
      bad++;
      $display("FAIL timeout_txn: got %0d want %0d", txn_count, exp_txn);
    end
    repeat (3) @(negedge CLK);
    total++;
    if ({timeout_err, cmd_ready} !== 2'b11) begin
      bad++;
      $display("FAIL timeout_sticky: timeout_err,cmd_ready=%b want 11", {timeout_err, cmd_ready});
    end
  endtask

  task automatic test_reset_midop();
    int k;
    bit ok;
    rdy_mode = 3;
    z_cfg[0] = 0;
    z_cfg[1] = 0;
    z_cfg[2] = 0;
    start_cmd(1'b1, 1'b0, ok);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (write_address !== 3'd5 && k < 100);
    total++;
    if (!ok || write_address !== 3'd5) begin
      bad++;
      $display("FAIL midop_reach_wr_b: write_address=%0d want 5", write_address);
    end
    rdy_mode = 0;
    @(posedge CLK);
    #2;
    total++;
    if (write_en !== 1'b1) begin
      bad++;
      $display("FAIL midop_setup: write_en=%b want 1 before reset", write_en);
    end
    RST = 1'b1;
    #1;
    total++;
    if ({write_en, cmd_ready, rsp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL midop_reset: write_en,cmd_ready,rsp_valid=%b want 000", {write_en, cmd_ready, rsp_valid});
    end
    total++;
    if ({read_en, timeout_err, txn_count} !== '0) begin
      bad++;
      $display("FAIL midop_clear: read_en=%b timeout_err=%b txn_count=%0d want 0 0 0",
               read_en, timeout_err, txn_count);
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    exp_txn = 0;
    run_cmd(1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 7);
  endtask

  initial begin
    RST = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 1'b0;
    cmd_b = 1'b0;
    rsp_ready = 1'b0;
    z_cfg[0] = 0;
    z_cfg[1] = 0;
    z_cfg[2] = 0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_a_full_stall();
    test_rsp_wrap();
    test_timeout();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifc_initiator.md
Name: ifc_initiator

Overview:
- Bus initiator for the OR-unit register interface; drives the write_*/read_* port set from the requester side.
- Accepts one operand pair (a, b) per command and, per operand, polls the A/B FIFO status before writing it.
- Polls Y status, then reads the result Y and returns it on a valid/ready response channel.
- Sits between test or firmware-side command sources and the dut; one command is outstanding at a time.

Parameters:
- POLL_TIMEOUT, 64: maximum unsuccessful status polls per wait state; 0 disables the timeout.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  initiator accepts the command.
- cmd_a  in  1  operand A.
- cmd_b  in  1  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_y  out  1  result Y.
- write_address  out  3  bus write address.
- write_data  out  1  bus write data.
- write_en  out  1  write strobe.
- write_rdy  in  1  responder can take a write.
- read_address  out  3  bus read address.
- read_en  out  1  read strobe.
- read_data  in  1  read data, combinationally valid while read_rdy=1.
- read_rdy  in  1  responder can serve a read.
- timeout_err  out  1  sticky flag: a poll timed out.
- txn_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Address map:
  - 0: A status, 1 = not full.
  - 1: B status, 1 = not full.
  - 2: Y status, 1 = not empty.
  - 3: Y data.
  - 4: A data write.
  - 5: B data write.
- Bus rules:
  - A write fires in a cycle where write_en=1; write_en is only ever driven as (write state AND write_rdy).
  - A read fires where read_en=1; read_en = (read state AND read_rdy). read_data is sampled that same cycle.
  - write_en and read_en are never 1 in the same cycle.
  - Address and data outputs are 0 when not in a matching state.
- Reset (RST=1, asynchronous):
  - State goes to IDLE; timeout_err=0, txn_count=0, rsp_valid=0, rsp_y=0.
  - write_en=0, read_en=0; cmd_ready is forced to 0 while RST=1.
- FSM states: IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RSP.
- IDLE: cmd_ready=1. When cmd_valid=1, latch a and b, then go to POLL_A. There is no cycle of latency beyond the handshake.
- POLL_A (read_address=0): on a fired read, read_data=1 moves to WR_A; read_data=0 stays and increments the poll counter.
- WR_A (write_address=4, write_data=a): on a fired write, go to POLL_B.
- POLL_B / WR_B: same as A, using addresses 1 and 5.
- POLL_Y (read_address=2): on a fired read with read_data=1, go to RD_Y.
- RD_Y (read_address=3): on a fired read, capture read_data into rsp_y and go to RSP.
- RSP: rsp_valid=1 and rsp_y held stable until rsp_ready=1. On the handshake, txn_count+1 and go to IDLE.
- Minimum command-to-rsp_valid latency with all rdy and status=1 is 6 cycles; rsp_valid asserts in cycle 7 after acceptance.
- Poll counter:
  - Clears on entry to any POLL state.
  - Counts only fired reads returning 0; a cycle with read_rdy=0 does not count.
  - When POLL_TIMEOUT≠0 and the count reaches POLL_TIMEOUT, set timeout_err=1 and return to IDLE. The command is dropped with no response and txn_count is unchanged.
- timeout_err clears only on RST.
- txn_count wraps from 2^CNT_W−1 to 0.
- Reset mid-operation aborts immediately. Writes already issued to the dut are not undone, and recovering dut state is the system's responsibility.
- rsp_ready=1 outside RSP has no effect. cmd_valid during a busy period is held off by cmd_ready=0.

Decomposition:
- Package ifc_pkg holds:
  - Address constants ADDR_A_STS=0, ADDR_B_STS=1, ADDR_Y_STS=2, ADDR_Y_DATA=3, ADDR_A_DATA=4, ADDR_B_DATA=5.
  - The state enum ifc_init_state_t.
- One sub-module, ifc_poll_timer: clear/increment/expire poll counter parameterised by POLL_TIMEOUT, with a disable on 0.

Test Plan:
- Basic: responder always ready, statuses=1, Y data=a|b. Commands (0,0), (0,1), (1,0), (1,1) → rsp_y 0,1,1,1; txn_count=4; bus trace per command is read 0, write 4, read 1, write 5, read 2, read 3.
- Back-pressure: write_rdy and read_rdy low for 3 cycles at each step → no enable pulses while rdy=0; results identical; no dropped or duplicated writes.
- A-full stall: A status returns 0 for 10 polls, then 1, with POLL_TIMEOUT=64 → write to 4 occurs after the 11th poll; timeout_err=0.
- Timeout: Y status stuck at 0, POLL_TIMEOUT=8 → after exactly 8 zero polls timeout_err=1, FSM in IDLE, cmd_ready=1, no rsp_valid, txn_count unchanged.
- Response back-pressure and wrap: CNT_W=2, rsp_ready held 0 for 5 cycles → rsp_valid and rsp_y stable; after 4 handshakes txn_count=0.
- Reset mid-op: assert RST during WR_B → same-cycle write_en=0, cmd_ready=0, rsp_valid=0; after release the next command completes normally.
